// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// spi_master : SPI mode-0 master (8-bit, MSB first, active-low ncs) with
//              single-frame and burst chip-select sequencing.
// Revision   : 1.0
// ============================================================================

module spi_master #(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       last,
  input  logic       stop,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sck,
  output logic       mosi,
  output logic       ncs,
  input  logic       miso
);

  localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HALF_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] IDLE_END  = CW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4,
    S_BURST = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    edge_q, edge_d;
  logic [6:0]    tx_sr_q, tx_sr_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          last_q, last_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          ncs_q, ncs_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          miso_s1_q, miso_s2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    last_d    = last_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    ncs_d     = ncs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE, S_BURST: begin
        // From BURST the chip select is already asserted, so setup is skipped.
        if (start) begin
          state_d = (state_q == S_IDLE) ? S_SETUP : S_XFER;
          cnt_d   = '0;
          edge_d  = '0;
          tx_sr_d = tx_data[6:0];
          mosi_d  = tx_data[7];
          last_d  = last;
          sck_d   = 1'b0;
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
        end else if (state_q == S_BURST && stop) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      S_SETUP: begin
        if (cnt_q == SETUP_END) begin
          state_d = S_XFER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_XFER: begin
        if (cnt_q == HALF_END) begin
          cnt_d  = '0;
          edge_d = edge_q + 4'd1;
          sck_d  = ~sck_q;
          if (!sck_q) begin
            rx_sr_d = {rx_sr_q[6:0], miso_s2_q};
          end else if (edge_q == 4'd15) begin
            mosi_d    = 1'b0;
            rx_data_d = rx_sr_q;
            done_d    = 1'b1;
            if (last_q) begin
              state_d = S_HOLD;
            end else begin
              state_d = S_BURST;
              busy_d  = 1'b0;
            end
          end else begin
            mosi_d  = tx_sr_q[6];
            tx_sr_d = {tx_sr_q[5:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == HOLD_END) begin
          state_d = S_GAP;
          cnt_d   = '0;
          ncs_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == IDLE_END) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      last_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ncs_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      last_q    <= last_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      ncs_q     <= ncs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      miso_s1_q <= miso;
      miso_s2_q <= miso_s1_q;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign ncs     = ncs_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// tb_spi_master : randomized bench for spi_master with a mode-0 slave model
//                 and a timeline-based reference of the expected pin activity.
// Revision      : 1.0
// ============================================================================

module tb_spi_master;

  localparam int CLK_DIV  = 8;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_IDLE  = 8;
  localparam int XFER_LEN = 16 * CLK_DIV;

  localparam int M_IDLE  = 0;
  localparam int M_SEQ   = 1;
  localparam int M_BURST = 2;

  logic       clk = 1'b0;
  logic       nrst;
  logic       start, last, stop;
  logic [7:0] tx_data;
  logic       busy, done, sck, mosi, ncs;
  logic [7:0] rx_data;
  logic       miso = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  spi_master #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_IDLE (CS_IDLE)
  ) dut (
    .clk    (clk),
    .nrst   (nrst),
    .start  (start),
    .tx_data(tx_data),
    .last   (last),
    .stop   (stop),
    .busy   (busy),
    .done   (done),
    .rx_data(rx_data),
    .sck    (sck),
    .mosi   (mosi),
    .ncs    (ncs),
    .miso   (miso)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model (mode 0) ----------------
  logic [7:0] slv_src_q[$];
  logic [7:0] slv_sent_q[$];
  logic [7:0] slv_rx_q[$];
  logic [7:0] slv_cur, slv_rec;
  int slv_bit, slv_rise, rise_total = 0;

  function automatic logic [7:0] next_src();
    if (slv_src_q.size() > 0) return slv_src_q.pop_front();
    return 8'($urandom);
  endfunction

  always @(negedge ncs) begin
    slv_cur  = next_src();
    slv_bit  = 0;
    slv_rise = 0;
    miso     = slv_cur[7];
  end

  always @(posedge ncs) begin
    slv_bit  = 0;
    slv_rise = 0;
  end

  always @(posedge sck) if (!ncs) begin
    slv_rec = {slv_rec[6:0], mosi};
    slv_rise++;
    rise_total++;
    if (slv_rise == 8) begin
      slv_rx_q.push_back(slv_rec);
      slv_sent_q.push_back(slv_cur);
      slv_rise = 0;
    end
  end

  always @(negedge sck) if (!ncs) begin
    slv_bit++;
    if (slv_bit == 8) begin
      slv_bit = 0;
      slv_cur = next_src();
    end
    miso = slv_cur[7 - slv_bit];
  end

  // ---------------- pin monitors ----------------
  int done_cnt = 0, ncs_rise_cnt = 0, ncs_fall_cnt = 0;
  int low_run = 0, high_run = 0, last_low = 0, last_high = 0;

  always @(posedge ncs) ncs_rise_cnt++;
  always @(negedge ncs) ncs_fall_cnt++;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ncs) begin
      if (low_run > 0) last_low = low_run;
      low_run = 0;
      high_run++;
    end else begin
      if (high_run > 0) last_high = high_run;
      high_run = 0;
      low_run++;
    end
  end

  // ---------------- reference model ----------------
  // A frame is a timeline counted from the accepting edge: optional setup,
  // one 16*CLK_DIV transfer window, then hold+gap (or a hand-off to burst).
  int         m_mode = M_IDLE;
  int         m_t = 0, m_setup = 0;
  logic       m_hasx = 1'b0, m_last = 1'b0, m_done = 1'b0;
  logic [7:0] m_tx = 8'h00, m_rx = 8'h00;
  logic [7:0] exp_q[$];

  task automatic model_step();
    int xl;
    m_done = 1'b0;
    if (!nrst) begin
      m_mode = M_IDLE;
      m_rx   = 8'h00;
      m_t    = 0;
      return;
    end
    if (m_mode == M_IDLE || m_mode == M_BURST) begin
      if (start) begin
        m_setup = (m_mode == M_IDLE) ? CS_SETUP : 0;
        m_mode  = M_SEQ;
        m_t     = 1;
        m_hasx  = 1'b1;
        m_tx    = tx_data;
        m_last  = last;
      end else if (m_mode == M_BURST && stop) begin
        m_setup = 0;
        m_mode  = M_SEQ;
        m_t     = 1;
        m_hasx  = 1'b0;
        m_last  = 1'b1;
      end
    end else begin
      m_t++;
      xl = m_hasx ? XFER_LEN : 0;
      if (m_hasx && m_t == m_setup + xl + 1) begin
        m_done = 1'b1;
        if (slv_sent_q.size() > 0) m_rx = slv_sent_q.pop_front();
        else check("slave_byte_available", 0, 1);
        exp_q.push_back(m_tx);
        if (!m_last) m_mode = M_BURST;
      end
      if (m_mode == M_SEQ && m_t == m_setup + xl + CS_HOLD + CS_IDLE + 1) m_mode = M_IDLE;
    end
  endtask

  // returns {ncs, sck, mosi, busy}
  function automatic logic [3:0] model_pins();
    int xl, x, u;
    if (m_mode == M_IDLE)  return 4'b1000;
    if (m_mode == M_BURST) return 4'b0000;
    xl = m_hasx ? XFER_LEN : 0;
    if (m_t <= m_setup) return {1'b0, 1'b0, m_tx[7], 1'b1};
    if (m_t <= m_setup + xl) begin
      x = m_t - m_setup - 1;
      return {1'b0, 1'(((x / CLK_DIV) % 2) == 1), m_tx[7 - x / (2 * CLK_DIV)], 1'b1};
    end
    u = m_t - m_setup - xl;
    return {1'(u > CS_HOLD), 1'b0, 1'b0, 1'b1};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("pins ncs/sck/mosi/busy/done/rx",
            {19'd0, ncs, sck, mosi, busy, done, rx_data},
            {19'd0, model_pins(), m_done, m_rx});
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d, input logic l, input logic s);
    start   = 1'b1;
    tx_data = d;
    last    = l;
    stop    = s;
    @(negedge clk);
    start   = 1'b0;
    stop    = 1'b0;
    tx_data = 8'($urandom);
    last    = 1'($urandom);
  endtask

  task automatic pulse_start_junk();
    start   = 1'b1;
    tx_data = 8'($urandom);
    last    = 1'($urandom);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (m_mode == M_SEQ && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("wait_ready_timeout", 1, 0);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, f0, rr0;
    logic [7:0] rx_keep;
    int nb;
    logic use_stop, lst, stp;

    nrst = 1'b0; start = 1'b0; stop = 1'b0; last = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ncs", ncs, 1);
    check("reset_sck", sck, 0);
    check("reset_busy", busy, 0);
    check("reset_rx", rx_data, 8'h00);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // single frame A5 out, 3C in
    d0 = done_cnt; r0 = rise_total;
    slv_src_q.push_back(8'h3C);
    send(8'hA5, 1'b1, 1'b0);
    wait_ready();
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_slave_rec", slv_rx_q[slv_rx_q.size()-1], 8'hA5);
    check("t1_ncs_low_len", last_low, CS_SETUP + XFER_LEN + CS_HOLD);
    check("t1_rises", rise_total - r0, 8);
    check("t1_done_pulses", done_cnt - d0, 1);

    // burst 01 then FE
    d0 = done_cnt; r0 = rise_total; rr0 = ncs_rise_cnt;
    slv_src_q.push_back(8'h11);
    slv_src_q.push_back(8'h22);
    send(8'h01, 1'b0, 1'b0);
    wait_ready();
    check("t2_busy_in_burst", busy, 0);
    check("t2_ncs_in_burst", ncs, 0);
    send(8'hFE, 1'b1, 1'b0);
    wait_ready();
    check("t2_ncs_rises", ncs_rise_cnt - rr0, 1);
    check("t2_rises", rise_total - r0, 16);
    check("t2_done_pulses", done_cnt - d0, 2);
    check("t2_slave_rec0", slv_rx_q[slv_rx_q.size()-2], 8'h01);
    check("t2_slave_rec1", slv_rx_q[slv_rx_q.size()-1], 8'hFE);
    check("t2_rx_data", rx_data, 8'h22);

    // starts during SETUP, XFER and GAP are dropped
    d0 = done_cnt; f0 = ncs_fall_cnt;
    send(8'h96, 1'b1, 1'b0);
    pulse_start_junk();
    repeat (40) @(negedge clk);
    pulse_start_junk();
    repeat (96) @(negedge clk);
    #1;
    check("t3_gap_busy", busy, 1);
    check("t3_gap_ncs", ncs, 1);
    pulse_start_junk();
    wait_ready();
    check("t3_busy_after", busy, 0);
    repeat (3) @(negedge clk);
    #1;
    check("t3_no_queued_frame", ncs, 1);
    check("t3_frames", ncs_fall_cnt - f0, 1);
    check("t3_done_pulses", done_cnt - d0, 1);

    // burst ended by stop
    send(8'h3A, 1'b0, 1'b0);
    wait_ready();
    rx_keep = rx_data; r0 = rise_total;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("t4_hold_ncs", ncs, 0);
    @(negedge clk);
    #1;
    check("t4_gap_ncs", ncs, 1);
    check("t4_gap_busy", busy, 1);
    wait_ready();
    check("t4_rx_unchanged", rx_data, rx_keep);
    check("t4_no_sck", rise_total - r0, 0);
    check("t4_busy_idle", busy, 0);

    // reset during bit 4 (sck low half), then a clean frame
    send(8'hC3, 1'b1, 1'b0);
    repeat (CS_SETUP + 4 * 2 * CLK_DIV + 2) @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("t5_ncs", ncs, 1);
    check("t5_sck", sck, 0);
    check("t5_mosi", mosi, 0);
    check("t5_busy", busy, 0);
    check("t5_rx", rx_data, 8'h00);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    slv_src_q.push_back(8'h77);
    send(8'h5A, 1'b1, 1'b0);
    wait_ready();
    check("t5_slave_rec", slv_rx_q[slv_rx_q.size()-1], 8'h5A);
    check("t5_rx_after", rx_data, 8'h77);

    // back-to-back frames
    send(8'($urandom), 1'b1, 1'b0);
    wait_ready();
    send(8'($urandom), 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("t6_ncs_high_len", last_high, CS_IDLE + 1);
    wait_ready();

    // randomized traffic
    for (int k = 0; k < 25; k++) begin
      nb = $urandom_range(1, 3);
      use_stop = 1'($urandom_range(0, 1));
      for (int b = 0; b < nb; b++) begin
        lst = (b == nb - 1) && !use_stop;
        stp = (b > 0) && ($urandom_range(0, 3) == 0);
        send(8'($urandom), lst, stp);
        repeat ($urandom_range(0, 60)) @(negedge clk);
        if (m_mode == M_SEQ) begin
          stop = 1'($urandom_range(0, 1));
          pulse_start_junk();
          stop = 1'b0;
        end
        wait_ready();
        @(negedge clk);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      if (use_stop) begin
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_ready();
        @(negedge clk);
      end
    end

    check("byte_count", slv_rx_q.size(), exp_q.size());
    for (int i = 0; i < slv_rx_q.size() && i < exp_q.size(); i++)
      check("slave_byte", slv_rx_q[i], exp_q[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
